// File: rtl/ptp_reg_pkg.sv
// Shared constants for the PTP register slave: address map, reset values and field positions.
package ptp_reg_pkg;

    localparam logic [7:0] ADDR_CTRL      = 8'h00;
    localparam logic [7:0] ADDR_PRIO      = 8'h01;
    localparam logic [7:0] ADDR_INTV      = 8'h02;
    localparam logic [7:0] ADDR_ROLE      = 8'h03;
    localparam logic [7:0] ADDR_STATE     = 8'h04;
    localparam logic [7:0] ADDR_PDELAY_LO = 8'h10;
    localparam logic [7:0] ADDR_PDELAY_HI = 8'h11;
    localparam logic [7:0] ADDR_FWD_LO    = 8'h12;
    localparam logic [7:0] ADDR_FWD_HI    = 8'h13;
    localparam logic [7:0] ADDR_OFFSET_LO = 8'h14;
    localparam logic [7:0] ADDR_OFFSET_HI = 8'h15;
    localparam logic [7:0] ADDR_OFFSIGN   = 8'h16;
    localparam logic [7:0] ADDR_SYNC_CNT  = 8'h20;
    localparam logic [7:0] ADDR_PREQ_CNT  = 8'h21;

    localparam logic [15:0] RST_CTRL = 16'h0000;
    localparam logic [15:0] RST_PRIO = 16'hF6F8;
    localparam logic [15:0] RST_INTV = 16'h00FD;

    localparam int CTRL_ENABLE_BIT  = 0;
    localparam int CTRL_TWOSTEP_BIT = 1;
    localparam int PRIO1_LSB        = 8;
    localparam int PRIO2_LSB        = 0;
    localparam int INTV_PDELAY_LSB  = 8;
    localparam int INTV_SYNC_LSB    = 0;

    localparam logic [15:0] CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/ptp_reg_snapshot32.sv
// 32-bit status value with a live register and a high-half shadow loaded when the low half is read,
// so a lo-then-hi read pair always returns one consistent sample.
module ptp_reg_snapshot32 (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] value,
    input  logic        value_valid,
    input  logic        sign,
    input  logic        lo_read,
    output logic [31:0] live,
    output logic [15:0] shadow_hi,
    output logic        shadow_sign
);

    logic live_sign;

    // Shadow samples the pre-update live value, so a coinciding valid never splits a pair.
    always_ff @(posedge clk) begin
        if (rst) begin
            live        <= 32'h0000_0000;
            live_sign   <= 1'b0;
            shadow_hi   <= 16'h0000;
            shadow_sign <= 1'b0;
        end else begin
            if (value_valid) begin
                live      <= value;
                live_sign <= sign;
            end
            if (lo_read) begin
                shadow_hi   <= live[31:16];
                shadow_sign <= live_sign;
            end
        end
    end

endmodule

// File: rtl/ptp_reg_slave.sv
// Register-bus responder for the PTP core: writable configuration, captured datapath status,
// saturating event counters and a registered read port with one-cycle latency.
module ptp_reg_slave
    import ptp_reg_pkg::*;
#(
    parameter int REG_ADDR_BUS_WIDTH = 8,
    parameter int REG_DATA_BUS_WIDTH = 16,
    parameter int PORT_NUM           = 8,
    parameter int TIMESTAMP_WIDTH    = 80
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_ptp_reg_bus_we,
    input  logic [REG_ADDR_BUS_WIDTH-1:0] i_ptp_reg_bus_we_addr,
    input  logic [REG_DATA_BUS_WIDTH-1:0] i_ptp_reg_bus_we_din,
    input  logic                          i_ptp_reg_bus_we_din_v,
    input  logic                          i_ptp_reg_bus_rd,
    input  logic [REG_ADDR_BUS_WIDTH-1:0] i_ptp_reg_bus_rd_addr,
    output logic [REG_DATA_BUS_WIDTH-1:0] o_ptp_reg_bus_rd_dout,
    output logic                          o_ptp_reg_bus_rd_dout_v,
    input  logic [PORT_NUM*2-1:0]         i_bcm_port_role,
    input  logic                          i_bcm_port_valid,
    input  logic [2:0]                    i_ptp_bcm_state,
    input  logic                          i_ptp_bcm_state_valid,
    input  logic [31:0]                   i_pdelay_time,
    input  logic                          i_pdelay_time_valid,
    input  logic [31:0]                   i_forward_time,
    input  logic                          i_forward_time_valid,
    input  logic [TIMESTAMP_WIDTH-1:0]    i_slave_clockoffset,
    input  logic                          i_slave_clockoffset_sign,
    input  logic                          i_slave_clockoffset_valid,
    input  logic                          i_sync_valid,
    input  logic                          i_pdelay_req_valid,
    output logic                          o_ptp_enable,
    output logic                          o_twostep,
    output logic [7:0]                    o_priority1,
    output logic [7:0]                    o_priority2,
    output logic [7:0]                    o_log_sync_interval,
    output logic [7:0]                    o_log_pdelay_interval
);

    localparam int AW = REG_ADDR_BUS_WIDTH;
    localparam int RW = PORT_NUM * 2;

    function automatic logic addr_is(input logic [AW-1:0] addr, input logic [7:0] reg_addr);
        return addr == AW'(reg_addr);
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] cnt);
        return (cnt == CNT_MAX) ? cnt : cnt + 16'd1;
    endfunction

    logic        wr_en;
    logic [15:0] wr_data;
    logic [1:0]  ctrl_reg;
    logic [15:0] prio_reg;
    logic [15:0] intv_reg;
    logic [RW-1:0] role_reg;
    logic [2:0]  state_reg;
    logic [15:0] sync_cnt;
    logic [15:0] preq_cnt;

    logic [31:0] pdelay_live, fwd_live, offset_live;
    logic [15:0] pdelay_shadow_hi, fwd_shadow_hi, offset_shadow_hi;
    logic        offset_shadow_sign;
    logic        unused_pdelay_sign, unused_fwd_sign, unused_offset_hi;

    logic [15:0] rd_word;
    logic [15:0] rd_data_p1;
    logic        vld_p1;

    assign wr_en   = i_ptp_reg_bus_we && i_ptp_reg_bus_we_din_v;
    assign wr_data = 16'(i_ptp_reg_bus_we_din);

    assign unused_offset_hi = ^i_slave_clockoffset[TIMESTAMP_WIDTH-1:32];

    // Configuration registers; read-only and unmapped addresses fall through untouched.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ctrl_reg <= RST_CTRL[1:0];
            prio_reg <= RST_PRIO;
            intv_reg <= RST_INTV;
        end else if (wr_en) begin
            if (addr_is(i_ptp_reg_bus_we_addr, ADDR_CTRL)) ctrl_reg <= wr_data[1:0];
            if (addr_is(i_ptp_reg_bus_we_addr, ADDR_PRIO)) prio_reg <= wr_data;
            if (addr_is(i_ptp_reg_bus_we_addr, ADDR_INTV)) intv_reg <= wr_data;
        end
    end

    assign o_ptp_enable          = ctrl_reg[CTRL_ENABLE_BIT];
    assign o_twostep             = ctrl_reg[CTRL_TWOSTEP_BIT];
    assign o_priority1           = prio_reg[PRIO1_LSB +: 8];
    assign o_priority2           = prio_reg[PRIO2_LSB +: 8];
    assign o_log_pdelay_interval = intv_reg[INTV_PDELAY_LSB +: 8];
    assign o_log_sync_interval   = intv_reg[INTV_SYNC_LSB +: 8];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            role_reg  <= '0;
            state_reg <= 3'd0;
        end else begin
            if (i_bcm_port_valid)      role_reg  <= i_bcm_port_role;
            if (i_ptp_bcm_state_valid) state_reg <= i_ptp_bcm_state;
        end
    end

    // A clear write beats a same-cycle event pulse.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync_cnt <= 16'h0000;
            preq_cnt <= 16'h0000;
        end else begin
            if (wr_en && addr_is(i_ptp_reg_bus_we_addr, ADDR_SYNC_CNT)) sync_cnt <= 16'h0000;
            else if (i_sync_valid)                                       sync_cnt <= sat_inc16(sync_cnt);
            if (wr_en && addr_is(i_ptp_reg_bus_we_addr, ADDR_PREQ_CNT)) preq_cnt <= 16'h0000;
            else if (i_pdelay_req_valid)                                 preq_cnt <= sat_inc16(preq_cnt);
        end
    end

    ptp_reg_snapshot32 u_snap_pdelay (
        .clk         (i_clk),
        .rst         (i_rst),
        .value       (i_pdelay_time),
        .value_valid (i_pdelay_time_valid),
        .sign        (1'b0),
        .lo_read     (i_ptp_reg_bus_rd && addr_is(i_ptp_reg_bus_rd_addr, ADDR_PDELAY_LO)),
        .live        (pdelay_live),
        .shadow_hi   (pdelay_shadow_hi),
        .shadow_sign (unused_pdelay_sign)
    );

    ptp_reg_snapshot32 u_snap_fwd (
        .clk         (i_clk),
        .rst         (i_rst),
        .value       (i_forward_time),
        .value_valid (i_forward_time_valid),
        .sign        (1'b0),
        .lo_read     (i_ptp_reg_bus_rd && addr_is(i_ptp_reg_bus_rd_addr, ADDR_FWD_LO)),
        .live        (fwd_live),
        .shadow_hi   (fwd_shadow_hi),
        .shadow_sign (unused_fwd_sign)
    );

    ptp_reg_snapshot32 u_snap_offset (
        .clk         (i_clk),
        .rst         (i_rst),
        .value       (i_slave_clockoffset[31:0]),
        .value_valid (i_slave_clockoffset_valid),
        .sign        (i_slave_clockoffset_sign),
        .lo_read     (i_ptp_reg_bus_rd && addr_is(i_ptp_reg_bus_rd_addr, ADDR_OFFSET_LO)),
        .live        (offset_live),
        .shadow_hi   (offset_shadow_hi),
        .shadow_sign (offset_shadow_sign)
    );

    always_comb begin
        rd_word = 16'h0000;
        case (i_ptp_reg_bus_rd_addr)
            AW'(ADDR_CTRL):      rd_word = {14'h0000, ctrl_reg};
            AW'(ADDR_PRIO):      rd_word = prio_reg;
            AW'(ADDR_INTV):      rd_word = intv_reg;
            AW'(ADDR_ROLE):      rd_word = 16'(role_reg);
            AW'(ADDR_STATE):     rd_word = {13'h0000, state_reg};
            AW'(ADDR_PDELAY_LO): rd_word = pdelay_live[15:0];
            AW'(ADDR_PDELAY_HI): rd_word = pdelay_shadow_hi;
            AW'(ADDR_FWD_LO):    rd_word = fwd_live[15:0];
            AW'(ADDR_FWD_HI):    rd_word = fwd_shadow_hi;
            AW'(ADDR_OFFSET_LO): rd_word = offset_live[15:0];
            AW'(ADDR_OFFSET_HI): rd_word = offset_shadow_hi;
            AW'(ADDR_OFFSIGN):   rd_word = {15'h0000, offset_shadow_sign};
            AW'(ADDR_SYNC_CNT):  rd_word = sync_cnt;
            AW'(ADDR_PREQ_CNT):  rd_word = preq_cnt;
            default:             rd_word = 16'h0000;
        endcase
    end

    // Stage p1: registered read data; holds its value between reads.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            vld_p1     <= 1'b0;
            rd_data_p1 <= 16'h0000;
        end else begin
            vld_p1 <= i_ptp_reg_bus_rd;
            if (i_ptp_reg_bus_rd) rd_data_p1 <= rd_word;
        end
    end

    assign o_ptp_reg_bus_rd_dout   = REG_DATA_BUS_WIDTH'(rd_data_p1);
    assign o_ptp_reg_bus_rd_dout_v = vld_p1;

endmodule
